// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - eight-way round-robin arbiter with registered grant and hold timeout
//
// Shares one downstream resource among eight requesters. The search for a
// winner starts at a rotating priority pointer, so no requester can be starved.
//
// Parameters:
//   MAX_HOLD     maximum consecutive cycles a grant may be held (0..255, 0 = no timeout)
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req[7:0]     request vector, bit i = requester i
//   done         current owner has finished (ignored while no grant is held)
//   grant[7:0]   registered one-hot grant, zero when idle
//   grant_id[2:0] registered index of the granted requester (holds after release)
//   grant_valid  registered, high while a grant is held
//   timeout      registered one-cycle pulse when the hold limit alone forced a release

module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value seen on the last permitted cycle of a grant.
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] cnt;

    logic [2:0] winner;
    logic       any_req;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_hold;
    logic       release_now;

    // Rotating-priority search: walk offsets from farthest to nearest so the
    // requester closest to ptr (in wrap order) is the one left in winner.
    always_comb begin
        winner  = ptr;
        any_req = |req;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                winner = ptr + 3'(k);
            end
        end
    end

    assign rel_done    = done;
    assign rel_drop    = ~req[grant_id];
    assign rel_hold    = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    assign release_now = rel_done | rel_drop | rel_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            cnt         <= 8'd0;
            grant       <= 8'h00;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // ptr is deliberately left alone here; it only moves on release.
                    if (any_req) begin
                        grant_id    <= winner;
                        grant       <= 8'b1 << winner;
                        grant_valid <= 1'b1;
                        cnt         <= 8'd0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                        ptr         <= grant_id + 3'd1;
                        // A coincident done or request drop counts as a normal release.
                        timeout     <= rel_hold & ~rel_done & ~rel_drop;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8

module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        step();
        step();
        n_checks++;
        if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant got %h want 00", grant); end
        n_checks++;
        if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", grant_valid); end
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
        rst = 1'b0;
        step();
        n_checks++;
        if (grant !== 8'h01) begin n_fail++; $display("FAIL first_grant got %h want 01", grant); end
        n_checks++;
        if (grant_id !== 3'd0) begin n_fail++; $display("FAIL first_id got %0d want 0", grant_id); end
    endtask

    // Grant 0 is already held on entry; expect 0..7 then 0 again.
    task automatic test_rotation();
        logic [2:0] exp_id;
        logic [7:0] exp_grant;
        for (int k = 0; k <= 8; k++) begin
            exp_id    = 3'(k % 8);
            exp_grant = 8'h01 << exp_id;
            n_checks++;
            if (grant_valid !== 1'b1 || grant_id !== exp_id || grant !== exp_grant) begin
                n_fail++;
                $display("FAIL rotation_%0d got v=%b id=%0d g=%h want v=1 id=%0d g=%h",
                         k, grant_valid, grant_id, grant, exp_id, exp_grant);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            n_checks++;
            if (grant_valid !== 1'b0 || grant !== 8'h00) begin
                n_fail++;
                $display("FAIL rotation_gap_%0d got v=%b g=%h want v=0 g=00", k, grant_valid, grant);
            end
            if (k != 8) step();
        end
    endtask

    // Pointer is 1 on entry.
    task automatic test_pointer_skip();
        req = 8'b0000_0100;
        step();
        n_checks++;
        if (grant_id !== 3'd2) begin n_fail++; $display("FAIL skip_setup_id got %0d want 2", grant_id); end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'b0000_0101;
        step();
        n_checks++;
        if (grant_id !== 3'd0 || grant !== 8'h01) begin
            n_fail++; $display("FAIL skip_wrap got id=%0d g=%h want id=0 g=01", grant_id, grant);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        n_checks++;
        if (grant_id !== 3'd2 || grant !== 8'h04) begin
            n_fail++; $display("FAIL skip_next got id=%0d g=%h want id=2 g=04", grant_id, grant);
        end
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;
    endtask

    task automatic test_req_drop();
        req = 8'h20;
        step();
        n_checks++;
        if (grant_id !== 3'd5 || grant_valid !== 1'b1) begin
            n_fail++; $display("FAIL drop_setup got id=%0d v=%b want id=5 v=1", grant_id, grant_valid);
        end
        req = 8'h00;
        step();
        n_checks++;
        if (grant_valid !== 1'b0 || grant !== 8'h00 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL drop_release got v=%b g=%h to=%b want v=0 g=00 to=0",
                               grant_valid, grant, timeout);
        end
        n_checks++;
        if (grant_id !== 3'd5) begin n_fail++; $display("FAIL drop_id_hold got %0d want 5", grant_id); end
        // ptr must now be 6: with 5 and 6 requesting, 6 wins.
        req = 8'h60;
        step();
        n_checks++;
        if (grant_id !== 3'd6) begin n_fail++; $display("FAIL drop_ptr got id=%0d want 6", grant_id); end
        req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        req = 8'h10;
        step();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (grant_valid !== 1'b1 || grant_id !== 3'd4 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL hold_cycle_%0d got v=%b id=%0d to=%b want v=1 id=4 to=0",
                                   c, grant_valid, grant_id, timeout);
            end
            step();
        end
        n_checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_pulse got v=%b to=%b want v=0 to=1", grant_valid, timeout);
        end
        step();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_id !== 3'd4 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL regrant got v=%b id=%0d to=%b want v=1 id=4 to=0",
                               grant_valid, grant_id, timeout);
        end
        step();
        step();
        step();
        n_checks++;
        if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL hold_4th got v=%b want 1", grant_valid); end
        done = 1'b1;
        step();
        done = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL done_at_limit got v=%b to=%b want v=0 to=0", grant_valid, timeout);
        end
        req = 8'h00;
        step();
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL done_at_limit_late got to=%b want 0", timeout); end
    endtask

    task automatic test_async_reset();
        req = 8'h40;
        step();
        n_checks++;
        if (grant !== 8'h40) begin n_fail++; $display("FAIL async_setup got g=%h want 40", grant); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_drop got g=%h v=%b want g=00 v=0", grant, grant_valid);
        end
        req = 8'hC0;
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (grant_id !== 3'd6 || grant !== 8'h40 || grant_valid !== 1'b1) begin
            n_fail++; $display("FAIL async_first got id=%0d g=%h v=%b want id=6 g=40 v=1",
                               grant_id, grant, grant_valid);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #1;
        test_reset();
        test_rotation();
        test_pointer_skip();
        test_req_drop();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
